operand_select_stage: RTL and testbench



---
 rtl/operand_select_stage.sv | 93 +++++++++
 tb/tb_operand_select_stage.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/operand_select_stage.sv
// Operand select stage: picks one of NSRC sources (or zero) and holds it
// in a 2-entry skid buffer behind a valid/ready handshake.
module operand_select_stage #(
    parameter int WIDTH = 8,
    parameter int NSRC  = 4,
    parameter int SEL_W = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NSRC*WIDTH-1:0]   SrcData,
    input  logic [SEL_W-1:0]        SrcSel,
    input  logic                    ForceZero,
    input  logic                    InValid,
    output logic                    InReady,
    output logic [WIDTH-1:0]        OutData,
    output logic                    OutValid,
    input  logic                    OutReady,
    output logic                    SelErr,
    input  logic                    ErrClr
);

    logic [WIDTH-1:0] sel_data;
    logic             sel_hit;
    logic             sel_bad;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic [WIDTH-1:0] skid_data;
    logic             skid_valid;
    logic             sel_err;
    logic             accept;
    logic             consume;

    always_comb begin
        sel_data = '0;
        sel_hit  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (SrcSel == SEL_W'(i)) begin
                sel_data = SrcData[i*WIDTH +: WIDTH];
                sel_hit  = 1'b1;
            end
        end
        if (ForceZero) begin
            sel_data = '0;
        end
        sel_bad = !ForceZero && !sel_hit;
    end

    assign accept  = InValid && !skid_valid;
    assign consume = out_valid && OutReady;

    // Occupancy is encoded directly in out_valid/skid_valid:
    // EMPTY = 00, ONE = 10, FULL = 11.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
            sel_err    <= 1'b0;
        end else begin
            if (!out_valid) begin
                if (accept) begin
                    out_data  <= sel_data;
                    out_valid <= 1'b1;
                end
            end else if (!skid_valid) begin
                if (accept && consume) begin
                    out_data <= sel_data;
                end else if (accept) begin
                    skid_data  <= sel_data;
                    skid_valid <= 1'b1;
                end else if (consume) begin
                    out_valid <= 1'b0;
                end
            end else if (consume) begin
                out_data   <= skid_data;
                skid_valid <= 1'b0;
            end

            if (accept && sel_bad) begin
                sel_err <= 1'b1;
            end else if (ErrClr) begin
                sel_err <= 1'b0;
            end
        end
    end

    assign InReady  = !skid_valid;
    assign OutData  = out_data;
    assign OutValid = out_valid;
    assign SelErr   = sel_err;

endmodule

// File: tb/tb_operand_select_stage.sv
// Scoreboard bench for operand_select_stage: a 4-source instance for
// data path / backpressure / reset, and a 3-source instance for SelErr.
module tb_operand_select_stage;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic [31:0] SrcData = '0;
    logic [1:0]  SrcSel = '0;
    logic        ForceZero = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [7:0]  OutData;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic        SelErr;
    logic        ErrClr = 1'b0;

    logic [23:0] e_SrcData = 24'h33_22_11;
    logic [1:0]  e_SrcSel = '0;
    logic        e_ForceZero = 1'b0;
    logic        e_InValid = 1'b0;
    logic        e_InReady;
    logic [7:0]  e_OutData;
    logic        e_OutValid;
    logic        e_OutReady = 1'b1;
    logic        e_SelErr;
    logic        e_ErrClr = 1'b0;

    int compared = 0;
    int mismatched = 0;
    logic [7:0] q[$];
    logic [7:0] q2[$];

    always #5 clk = ~clk;

    operand_select_stage #(.WIDTH(8), .NSRC(4), .SEL_W(2)) dut (
        .clk(clk), .reset(reset),
        .SrcData(SrcData), .SrcSel(SrcSel), .ForceZero(ForceZero),
        .InValid(InValid), .InReady(InReady),
        .OutData(OutData), .OutValid(OutValid), .OutReady(OutReady),
        .SelErr(SelErr), .ErrClr(ErrClr)
    );

    operand_select_stage #(.WIDTH(8), .NSRC(3), .SEL_W(2)) dut_err (
        .clk(clk), .reset(reset),
        .SrcData(e_SrcData), .SrcSel(e_SrcSel), .ForceZero(e_ForceZero),
        .InValid(e_InValid), .InReady(e_InReady),
        .OutData(e_OutData), .OutValid(e_OutValid), .OutReady(e_OutReady),
        .SelErr(e_SelErr), .ErrClr(e_ErrClr)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && OutValid && OutReady) begin
            if (q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL main_unexpected: got %0h expected none", OutData);
            end else begin
                check("main_out", OutData, q.pop_front());
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && e_OutValid && e_OutReady) begin
            if (q2.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL err_unexpected: got %0h expected none", e_OutData);
            end else begin
                check("err_out", e_OutData, q2.pop_front());
            end
        end
    end

    // Leaves InValid high so back-to-back calls form a continuous stream.
    task automatic send(input logic [31:0] d, input logic [1:0] s,
                        input logic fz, input logic [7:0] exp);
        logic rdy;
        bit   done;
        done = 1'b0;
        SrcData   = d;
        SrcSel    = s;
        ForceZero = fz;
        InValid   = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            rdy = InReady;
            @(posedge clk);
            #1;
            if (rdy) done = 1'b1;
        end
        if (done) begin
            q.push_back(exp);
        end else begin
            check("send_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idle();
        InValid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && (q.size() != 0 || q2.size() != 0); n++) begin
            @(posedge clk);
            #1;
        end
        check("drain_empty", q.size() + q2.size(), 0);
    endtask

    task automatic e_beat(input logic [1:0] s, input logic fz,
                          input logic [7:0] exp);
        e_SrcSel    = s;
        e_ForceZero = fz;
        e_InValid   = 1'b1;
        @(posedge clk);
        #1;
        e_InValid = 1'b0;
        q2.push_back(exp);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_outvalid", OutValid, 1'b0);
        check("rst_inready", InReady, 1'b1);
        check("rst_outdata", OutData, 8'h00);
        check("rst_selerr", SelErr, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        OutReady = 1'b1;
        begin
            logic [7:0] pt_exp [4];
            pt_exp = '{8'h11, 8'h22, 8'h33, 8'h44};
            for (int i = 0; i < 4; i++) begin
                check("pt_inready", InReady, 1'b1);
                if (i > 0) check("pt_outvalid", OutValid, 1'b1);
                send(32'h44332211, 2'(i), 1'b0, pt_exp[i]);
            end
        end
        check("pt_outvalid_last", OutValid, 1'b1);
        idle();
        drain();

        send(32'h44332211, 2'd2, 1'b1, 8'h00);
        idle();
        check("fz_selerr", SelErr, 1'b0);
        drain();

        OutReady = 1'b0;
        send(32'h000000A1, 2'd0, 1'b0, 8'hA1);
        send(32'h000000B2, 2'd0, 1'b0, 8'hB2);
        check("bp_inready", InReady, 1'b0);
        check("bp_outvalid", OutValid, 1'b1);
        check("bp_hold", OutData, 8'hA1);
        fork
            send(32'h000000C3, 2'd0, 1'b0, 8'hC3);
            begin
                repeat (2) @(posedge clk);
                #1;
                check("bp_hold2", OutData, 8'hA1);
                OutReady = 1'b1;
                @(posedge clk);
                #1;
                check("bp_gap1", OutValid, 1'b1);
                @(posedge clk);
                #1;
                check("bp_gap2", OutValid, 1'b1);
            end
        join
        idle();
        drain();

        OutReady = 1'b0;
        send(32'h00000077, 2'd0, 1'b0, 8'h77);
        send(32'h00000088, 2'd0, 1'b0, 8'h88);
        idle();
        check("pre_rst_full", InReady, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("arst_outvalid", OutValid, 1'b0);
        check("arst_inready", InReady, 1'b1);
        check("arst_outdata", OutData, 8'h00);
        q.delete();
        #9;
        reset = 1'b0;
        check("post_rst_inready", InReady, 1'b1);
        check("post_rst_outvalid", OutValid, 1'b0);
        OutReady = 1'b1;
        @(posedge clk);
        #1;
        send(32'h0000005A, 2'd0, 1'b0, 8'h5A);
        idle();
        drain();
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_quiet", OutValid, 1'b0);

        e_beat(2'd1, 1'b0, 8'h22);
        check("err_good", e_SelErr, 1'b0);
        e_beat(2'd3, 1'b0, 8'h00);
        check("err_set", e_SelErr, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("err_sticky", e_SelErr, 1'b1);
        end
        e_ErrClr = 1'b1;
        @(posedge clk);
        #1;
        e_ErrClr = 1'b0;
        check("err_clr", e_SelErr, 1'b0);
        e_beat(2'd3, 1'b1, 8'h00);
        check("err_fz_noset", e_SelErr, 1'b0);
        e_ErrClr = 1'b1;
        e_beat(2'd3, 1'b0, 8'h00);
        e_ErrClr = 1'b0;
        check("err_set_wins", e_SelErr, 1'b1);
        e_beat(2'd2, 1'b0, 8'h33);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
